simon_core_param: RTL and testbench
===================================

SIMON_CORE_PARAM -- requirements
Module: simon_core_param

Interface
- REQ-001: Clock domain and reset SHALL be: one clock; reset is synchronous and active-high.
- REQ-002: Parameter NUM_COLORS, 4, number of buttons/colors, legal range 2..8.
- REQ-003: Parameter MAX_ROUNDS, 32, sequence memory depth; completing this round is a win.
- REQ-004: Parameter SHOW_CYCLES, 50000000, lit time per sequence step.
- REQ-005: Parameter GAP_CYCLES, 12500000, dark time after each sequence step.
- REQ-006: Parameter BLINK_CYCLES, 25000000, echo-blink time after a player press.
- REQ-007: Parameter TIMEOUT_CYCLES, 250000000, player inactivity limit.
- REQ-008: Parameter LFSR_SEED, 16'hACE1, nonzero LFSR reset value.
- REQ-009: Derived widths: CW = max(1, clog2(NUM_COLORS)); RW = clog2(MAX_ROUNDS+1).
- REQ-010: clk  input  1  system clock, all logic on rising edge.
- REQ-011: rst  input  1  synchronous active-high reset.
- REQ-012: start_btn  input  1  start/restart request, rising-edge detected.
- REQ-013: btn  input  NUM_COLORS  player buttons, bit i = color i.
- REQ-014: round  output  RW  current round count (score).
- REQ-015: color  output  CW  color index to display.
- REQ-016: color_en  output  1  display enable for color.
- REQ-017: game_over  output  1  level, high in LOSE.
- REQ-018: win  output  1  level, high in WIN.

Function
- REQ-019: States SHALL be IDLE, GETCOLOR, SHOW_ON, SHOW_GAP, PLAYER, ECHO, WIN, LOSE.
- REQ-020: start_btn and btn SHALL be registered once; press = input & ~registered input (rising edge); levels alone never act.
- REQ-021: IDLE/WIN/LOSE: start_btn edge -> round cleared to 0, next state GETCOLOR.
- REQ-022: GETCOLOR (exactly 1 cycle): memory[round] <= new color; round <= round+1; seq index <= 0; -> SHOW_ON.
- REQ-023: New color: v = lfsr[CW-1:0]; color = v >= NUM_COLORS ? v-NUM_COLORS : v.
- REQ-024: LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every cycle in every state, never reaches zero.
- REQ-025: SHOW_ON: color = memory[seq index], color_en = 1 for exactly SHOW_CYCLES cycles -> SHOW_GAP.
- REQ-026: SHOW_GAP: color_en = 0 for exactly GAP_CYCLES cycles; then seq index == round-1 -> PLAYER (player index 0, timeout timer 0), else seq index+1 -> SHOW_ON.
- REQ-027: PLAYER: color_en = 0; timeout timer increments each cycle; reaching TIMEOUT_CYCLES -> LOSE.
- REQ-028: PLAYER: any btn edge -> capture lowest-index edge bit as pressed color -> ECHO; simultaneous edges resolve to lowest index.
- REQ-029: btn edges outside PLAYER SHALL be ignored and not buffered.
- REQ-030: ECHO: color = captured color, color_en = 1 for exactly BLINK_CYCLES cycles; then compare with memory[player index].
- REQ-031: ECHO end: mismatch -> LOSE; match and player index < round-1 -> player index+1, timer cleared, PLAYER; match and last index -> WIN if round == MAX_ROUNDS else GETCOLOR.
- REQ-032: WIN/LOSE: color_en = 0, round holds final value, flag held until start_btn edge or rst.
- REQ-033: color SHALL be 0 whenever color_en = 0.
- REQ-034: Round counter SHALL never exceed MAX_ROUNDS; memory index never exceeds MAX_ROUNDS-1.

Reset
- REQ-035: rst high at a clock edge: state IDLE, round 0, color 0, color_en 0, win 0, game_over 0, lfsr LFSR_SEED, all timers/indices 0, edge registers 0; memory contents not reset.
- REQ-036: rst SHALL abort any state mid-operation; outputs reach reset values on the cycle after the rst edge.

Verification (NUM_COLORS=4, MAX_ROUNDS=3, SHOW=4, GAP=2, BLINK=3, TIMEOUT=20)
- REQ-037: rst, start_btn pulse -> GETCOLOR one cycle, round=1, then color_en high exactly 4 cycles, low 2, then PLAYER.
- REQ-038: Correct replay of all 3 rounds -> win=1, round=3, color_en=0 held; a later start_btn edge restarts at round=1.
- REQ-039: Wrong button in round 2 -> 3-cycle echo of the pressed color, then game_over=1, round=2.
- REQ-040: No press for 20 cycles in PLAYER -> game_over=1 on cycle 20; button held during SHOW_ON and still held in PLAYER -> no press registered.
- REQ-041: btn=4'b0110 edge in PLAYER -> captured color 1; btn edge in SHOW_ON -> ignored.
- REQ-042: rst mid-SHOW_ON -> next cycle all outputs 0; replay with identical start timing -> identical first color (LFSR reseeded).

Source files
------------

// File: rtl/simon_core_param.sv
// Parameterised Simon memory game: an LFSR picks colours, the sequence is
// replayed on the display and the player's presses are echoed and checked.
module simon_core_param #(
  parameter int NUM_COLORS     = 4,
  parameter int MAX_ROUNDS     = 32,
  parameter int SHOW_CYCLES    = 50000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int BLINK_CYCLES   = 25000000,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int CW = ($clog2(NUM_COLORS) < 1) ? 1 : $clog2(NUM_COLORS),
  localparam int RW = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_btn,
  input  logic [NUM_COLORS-1:0] btn,
  output logic [RW-1:0]         round,
  output logic [CW-1:0]         color,
  output logic                  color_en,
  output logic                  game_over,
  output logic                  win
);

  localparam int AW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;

  typedef enum logic [2:0] {
    IDLE, GETCOLOR, SHOW_ON, SHOW_GAP, PLAYER, ECHO, WIN, LOSE
  } state_t;

  state_t                state, state_n;
  logic                  start_q;
  logic [NUM_COLORS-1:0] btn_q;
  logic [15:0]           lfsr;
  logic [31:0]           timer, timer_n;
  logic [RW-1:0]         seq_idx, seq_idx_n;
  logic [RW-1:0]         player_idx, player_idx_n;
  logic [RW-1:0]         round_n;
  logic [CW-1:0]         pressed, pressed_n;
  logic [CW-1:0]         mem [MAX_ROUNDS];
  logic                  mem_we;

  logic                  start_edge;
  logic [NUM_COLORS-1:0] btn_edge;
  logic [CW-1:0]         first_edge;
  logic [CW-1:0]         lfsr_v;
  logic [CW-1:0]         new_color;
  logic [RW-1:0]         last_idx;

  assign start_edge = start_btn & ~start_q;
  assign btn_edge   = btn & ~btn_q;
  assign last_idx   = round - RW'(1);
  assign lfsr_v     = lfsr[CW-1:0];

  // Lowest-index button wins when several edges arrive together
  always_comb begin
    first_edge = '0;
    for (int i = NUM_COLORS - 1; i >= 0; i--) begin
      if (btn_edge[i]) first_edge = CW'(i);
    end
  end

  always_comb begin
    new_color = lfsr_v;
    if (int'(lfsr_v) >= NUM_COLORS) new_color = lfsr_v - CW'(NUM_COLORS);
  end

  always_comb begin
    state_n      = state;
    timer_n      = timer + 32'd1;
    seq_idx_n    = seq_idx;
    player_idx_n = player_idx;
    pressed_n    = pressed;
    round_n      = round;
    mem_we       = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        timer_n = '0;
        if (start_edge) begin
          round_n = '0;
          state_n = GETCOLOR;
        end
      end
      GETCOLOR: begin
        mem_we    = 1'b1;
        round_n   = round + RW'(1);
        seq_idx_n = '0;
        timer_n   = '0;
        state_n   = SHOW_ON;
      end
      SHOW_ON: begin
        if (timer == 32'(SHOW_CYCLES - 1)) begin
          timer_n = '0;
          state_n = SHOW_GAP;
        end
      end
      SHOW_GAP: begin
        if (timer == 32'(GAP_CYCLES - 1)) begin
          timer_n = '0;
          if (seq_idx == last_idx) begin
            player_idx_n = '0;
            state_n      = PLAYER;
          end else begin
            seq_idx_n = seq_idx + RW'(1);
            state_n   = SHOW_ON;
          end
        end
      end
      PLAYER: begin
        // A press in the final cycle still beats the timeout
        if (|btn_edge) begin
          pressed_n = first_edge;
          timer_n   = '0;
          state_n   = ECHO;
        end else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
          timer_n = '0;
          state_n = LOSE;
        end
      end
      ECHO: begin
        if (timer == 32'(BLINK_CYCLES - 1)) begin
          timer_n = '0;
          if (pressed != mem[player_idx[AW-1:0]]) begin
            state_n = LOSE;
          end else if (player_idx != last_idx) begin
            player_idx_n = player_idx + RW'(1);
            state_n      = PLAYER;
          end else if (round == RW'(MAX_ROUNDS)) begin
            state_n = WIN;
          end else begin
            state_n = GETCOLOR;
          end
        end
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      btn_q      <= '0;
      lfsr       <= LFSR_SEED;
      timer      <= '0;
      seq_idx    <= '0;
      player_idx <= '0;
      pressed    <= '0;
      round      <= '0;
    end else begin
      state      <= state_n;
      start_q    <= start_btn;
      btn_q      <= btn;
      lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      timer      <= timer_n;
      seq_idx    <= seq_idx_n;
      player_idx <= player_idx_n;
      pressed    <= pressed_n;
      round      <= round_n;
    end
  end

  // Sequence memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[round[AW-1:0]] <= new_color;
  end

  always_comb begin
    color = '0;
    if (state == SHOW_ON)   color = mem[seq_idx[AW-1:0]];
    else if (state == ECHO) color = pressed;
  end

  assign color_en  = (state == SHOW_ON) || (state == ECHO);
  assign game_over = (state == LOSE);
  assign win       = (state == WIN);

endmodule

// File: tb/tb_simon_core_param.sv
// Scoreboard bench for simon_core_param: a driver plays scripted games and
// queues expected display pulses/outcomes; a monitor measures and checks them.
module tb_simon_core_param;

  localparam int N     = 4;
  localparam int MR    = 3;
  localparam int SHOW  = 4;
  localparam int GAP   = 2;
  localparam int BLINK = 3;
  localparam int TO    = 20;
  localparam int CWB   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int K_PULSE = 0;
  localparam int K_WIN   = 1;
  localparam int K_LOSE  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [1:0] round;
  logic [1:0] color;
  logic       color_en;
  logic       game_over;
  logic       win;

  simon_core_param #(
    .NUM_COLORS(N), .MAX_ROUNDS(MR), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP),
    .BLINK_CYCLES(BLINK), .TIMEOUT_CYCLES(TO), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .btn(btn),
    .round(round), .color(color), .color_en(color_en),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int color;
    int len;
    int rnd;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference LFSR: value the game's generator holds during the current cycle
  logic [15:0] ref_lfsr;
  always @(posedge clk) begin
    if (rst) ref_lfsr <= SEED;
    else     ref_lfsr <= {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int seq[$];
  int m_round;
  int pidx;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int lfsr_color(input logic [15:0] l);
    int v;
    v = int'(l) % (1 << CWB);
    return (v >= N) ? v - N : v;
  endfunction

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] press_pattern(input int c);
    logic [3:0] hi;
    hi = 4'($urandom) & ~4'((2 << c) - 1);
    return 4'(1 << c) | hi;
  endfunction

  task automatic push_exp(input int kind, input int c, input int len, input int rnd, input int gap);
    exp_t e;
    e.kind = kind; e.color = c; e.len = len; e.rnd = rnd; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: measures pulse color/length/preceding dark time and flag rises
  bit mon_en = 0;
  bit prev_en = 0, prev_win = 0, prev_go = 0;
  int low_run = 0, cur_len = 0, cur_color = 0, cur_round = 0, cur_gap = 0;
  bit steady = 1;

  task automatic pop_check(input int kind, input int c, input int len, input int rnd,
                           input int gap, input bit stdy);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL sb_unexpected: got event kind %0d, expected none at %0t", kind, $time);
    end else begin
      e = sb.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_round", rnd, e.rnd);
      if (e.gap >= 0) checkOutput("event_gap", gap, e.gap);
      if (kind == K_PULSE && e.kind == K_PULSE) begin
        checkOutput("pulse_color", c, e.color);
        checkOutput("pulse_len", len, e.len);
        checkOutput("pulse_steady", int'(stdy), 1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (color_en) begin
        if (!prev_en) begin
          cur_color = int'(color);
          cur_round = int'(round);
          cur_gap   = low_run;
          cur_len   = 0;
          steady    = 1;
        end else if (int'(color) != cur_color) begin
          steady = 0;
        end
        cur_len++;
        low_run = 0;
      end else begin
        checkOutput("dark_color_zero", int'(color), 0);
        if (prev_en) begin
          pop_check(K_PULSE, cur_color, cur_len, cur_round, cur_gap, steady);
          low_run = 0;
        end
      end
      if (win && !prev_win)      pop_check(K_WIN, 0, 0, int'(round), low_run, 1'b1);
      if (game_over && !prev_go) pop_check(K_LOSE, 0, 0, int'(round), low_run, 1'b1);
      if (!color_en) low_run++;
      prev_en  = color_en;
      prev_win = win;
      prev_go  = game_over;
    end
  end

  task automatic check_idle_outputs(input string tag);
    checkOutput({tag, "_round"}, int'(round), 0);
    checkOutput({tag, "_color"}, int'(color), 0);
    checkOutput({tag, "_color_en"}, int'(color_en), 0);
    checkOutput({tag, "_win"}, int'(win), 0);
    checkOutput({tag, "_game_over"}, int'(game_over), 0);
  endtask

  task automatic do_reset();
    start_btn = 1'b0;
    btn       = 4'b0000;
    rst       = 1'b1;
    tick(2);
    rst = 1'b0;
    check_idle_outputs("reset");
    mon_en = 1;
    tick(3);
  endtask

  task automatic start_game();
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
    checkOutput("getcolor_round", int'(round), 0);
    checkOutput("getcolor_dark", int'(color_en), 0);
    seq.delete();
    m_round = 0;
  endtask

  // Called in the colour-pick cycle; returns at the first cycle of player input
  task automatic new_round(input int mode);
    seq.push_back(lfsr_color(ref_lfsr));
    m_round++;
    pidx = 0;
    tick(1);
    for (int i = 0; i < m_round; i++)
      push_exp(K_PULSE, seq[i], SHOW, m_round, (i == 0) ? -1 : GAP);
    for (int k = 0; k < m_round * (SHOW + GAP); k++) begin
      if (mode == 1 && k == 1) btn = 4'b0100;
      if (mode == 1 && k == 2) btn = 4'b0000;
      if (mode == 2 && k == 0) btn = 4'b0001;
      tick(1);
    end
  endtask

  // res: 0 more input, 1 next round, 2 win, 3 lose
  task automatic applyStimulus(input logic [3:0] pat, input int d, input bit first, output int res);
    int c;
    tick(d);
    btn = pat;
    tick(1);
    btn = 4'b0000;
    c = lowest(pat);
    push_exp(K_PULSE, c, BLINK, m_round, (first ? GAP : 0) + d + 1);
    tick(BLINK);
    if (c != seq[pidx]) begin
      push_exp(K_LOSE, 0, 0, m_round, 0);
      res = 3;
    end else if (pidx < m_round - 1) begin
      pidx++;
      res = 0;
    end else if (m_round == MR) begin
      push_exp(K_WIN, 0, 0, m_round, 0);
      res = 2;
    end else begin
      res = 1;
    end
  endtask

  task automatic wait_timeout(input bit first);
    push_exp(K_LOSE, 0, 0, m_round, (first ? GAP : 0) + TO);
    tick(5);
    btn = 4'b0000;
    tick(TO - 5);
  endtask

  // Scenarios: 0 perfect win, 1 wrong press in round 2, 2 multi-bit press 0110,
  // 3 timeout with a button held through the show, 4 timeout mid-round 2
  task automatic play_game(input int scn);
    int res, mode, d;
    bit first;
    logic [3:0] pat;
    start_game();
    res = 1;
    while (res == 1) begin
      mode = (scn == 0 && m_round == 1) ? 1 : (scn == 3 && m_round == 0) ? 2 : 0;
      new_round(mode);
      first = 1;
      res = 0;
      while (res == 0) begin
        if ((scn == 3 && m_round == 1) || (scn == 4 && m_round == 2 && pidx == 1)) begin
          wait_timeout(first);
          res = 3;
        end else begin
          if (scn == 1 && m_round == 2 && pidx == 1)      pat = 4'(1 << ((seq[pidx] + 1) % N));
          else if (scn == 2 && m_round == 1 && pidx == 0) pat = 4'b0110;
          else                                            pat = press_pattern(seq[pidx]);
          d = $urandom_range(0, 15);
          applyStimulus(pat, d, first, res);
          first = 0;
        end
      end
    end
    tick(3);
    if (res == 2) begin
      checkOutput("win_hold", int'(win), 1);
      checkOutput("win_round", int'(round), MR);
      checkOutput("win_dark", int'(color_en), 0);
      checkOutput("win_no_lose", int'(game_over), 0);
    end else begin
      checkOutput("lose_hold", int'(game_over), 1);
      checkOutput("lose_round", int'(round), m_round);
      checkOutput("lose_dark", int'(color_en), 0);
      checkOutput("lose_no_win", int'(win), 0);
    end
  endtask

  task automatic reset_mid_show();
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
    push_exp(K_PULSE, lfsr_color(ref_lfsr), 3, 1, -1);
    tick(1);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_idle_outputs("midshow_reset");
    tick(3);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] starting simon_core_param bench");
    do_reset();
    play_game(0);
    play_game(1);
    play_game(2);
    play_game(3);
    play_game(4);
    play_game(0);
    reset_mid_show();
    play_game(0);
    tick(4);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
